// File: rtl/riscv_console.sv
// Memory-mapped console for the riscv data bus: TXDATA bytes are queued and sent as 8N1 UART,
// and an EXIT write latches a pass/fail code that is reported on done once the wire is drained.
module riscv_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        tx,
  output logic        done,
  output logic [7:0]  exit_code
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_EXIT   = 2'd2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_e;

  logic              readyQ;
  logic [31:0]       rdataQ, rdataD;
  logic              doneQ, doneD;
  logic              exitSeenQ;
  logic [7:0]        exitCodeQ;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtrQ, rdPtrQ;
  logic [CNT_W-1:0]  countQ, countD;
  logic              fullQ, emptyQ;

  txState_e          stateQ, stateD;
  logic [BAUD_W-1:0] baudQ, baudD;
  logic [2:0]        bitCntQ, bitCntD;
  logic [7:0]        shiftQ, shiftD;
  logic              txQ, txD;

  logic              hit;
  logic [1:0]        regSel;
  logic              txStore;
  logic              accept;
  logic              push;
  logic              pop;
  logic              exitWrite;
  logic              baudEnd;
  logic              txBusy;
  logic [7:0]        countByte;
  logic [31:0]       statusWord;
  logic [31:0]       readData;
  logic              unusedBits;

  assign unusedBits = ^{d_addr[1:0], d_wdata[31:8], d_wstrb[3:1]};

  // A full FIFO stalls only TXDATA stores; every other hit is acked immediately.
  assign hit       = (d_addr[31:4] == BASE_ADDR[31:4]);
  assign regSel    = d_addr[3:2];
  assign txStore   = d_we && (regSel == REG_TXDATA);
  assign accept    = d_valid && hit && !readyQ && !(txStore && fullQ);
  assign push      = accept && txStore && d_wstrb[0];
  assign exitWrite = accept && d_we && (regSel == REG_EXIT) && d_wstrb[0] && !exitSeenQ;
  assign pop       = (stateQ == TX_IDLE) && !emptyQ;

  assign txBusy     = (stateQ != TX_IDLE);
  assign countByte  = 8'(countQ);
  assign statusWord = {16'h0000, countByte, 5'b00000, txBusy, emptyQ, fullQ};

  always_comb begin
    readData = 32'h0000_0000;
    case (regSel)
      REG_STATUS: readData = statusWord;
      REG_EXIT:   readData = {23'h000000, exitSeenQ, exitCodeQ};
      default:    readData = 32'h0000_0000;
    endcase
  end

  always_comb begin
    rdataD = 32'h0000_0000;
    if (accept && !d_we) begin
      rdataD = readData;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      readyQ    <= 1'b0;
      rdataQ    <= 32'h0000_0000;
      exitSeenQ <= 1'b0;
      exitCodeQ <= 8'h00;
      doneQ     <= 1'b0;
    end else begin
      readyQ <= accept;
      rdataQ <= rdataD;
      doneQ  <= doneD;
      if (exitWrite) begin
        exitSeenQ <= 1'b1;
        exitCodeQ <= d_wdata[7:0];
      end
    end
  end

  // Drained means nothing queued, nothing on the wire and no byte arriving on this edge.
  always_comb begin
    doneD = doneQ;
    if (exitSeenQ && emptyQ && (stateQ == TX_IDLE) && !push) begin
      doneD = 1'b1;
    end
  end

  always_comb begin
    countD = countQ;
    case ({push, pop})
      2'b10:   countD = countQ + CNT_W'(1);
      2'b01:   countD = countQ - CNT_W'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtrQ] <= d_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      fullQ  <= 1'b0;
      emptyQ <= 1'b1;
    end else begin
      if (push) begin
        wrPtrQ <= wrPtrQ + PTR_W'(1);
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PTR_W'(1);
      end
      countQ <= countD;
      fullQ  <= (countD == CNT_W'(FIFO_DEPTH));
      emptyQ <= (countD == '0);
    end
  end

  // tx is registered, so each state drives the level of the bit that starts on its exit edge.
  assign baudEnd = (baudQ == BAUD_W'(CLK_DIV - 1));

  always_comb begin
    stateD  = stateQ;
    baudD   = baudQ;
    bitCntD = bitCntQ;
    shiftD  = shiftQ;
    txD     = txQ;
    case (stateQ)
      TX_IDLE: begin
        txD = 1'b1;
        if (!emptyQ) begin
          stateD = TX_START;
          shiftD = mem[rdPtrQ];
          txD    = 1'b0;
          baudD  = '0;
        end
      end
      TX_START: begin
        if (baudEnd) begin
          stateD  = TX_DATA;
          baudD   = '0;
          bitCntD = 3'd0;
          txD     = shiftQ[0];
        end else begin
          baudD = baudQ + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baudEnd) begin
          baudD = '0;
          if (bitCntQ == 3'd7) begin
            stateD = TX_STOP;
            txD    = 1'b1;
          end else begin
            bitCntD = bitCntQ + 3'd1;
            shiftD  = shiftQ >> 1;
            txD     = shiftQ[1];
          end
        end else begin
          baudD = baudQ + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        txD = 1'b1;
        if (baudEnd) begin
          stateD = TX_IDLE;
          baudD  = '0;
        end else begin
          baudD = baudQ + BAUD_W'(1);
        end
      end
      default: begin
        stateD = TX_IDLE;
        txD    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= TX_IDLE;
      baudQ   <= '0;
      bitCntQ <= 3'd0;
      shiftQ  <= 8'h00;
      txQ     <= 1'b1;
    end else begin
      stateQ  <= stateD;
      baudQ   <= baudD;
      bitCntQ <= bitCntD;
      shiftQ  <= shiftD;
      txQ     <= txD;
    end
  end

  assign d_ready   = readyQ;
  assign d_rdata   = rdataQ;
  assign tx        = txQ;
  assign done      = doneQ;
  assign exit_code = exitCodeQ;

endmodule

// File: tb/tb_riscv_console.sv
// Directed bench for riscv_console with CLK_DIV=4 and an 8-entry FIFO; a UART receiver
// process decodes tx into bytes and records the cycle at which each frame starts.
module tb_riscv_console;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dValid;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dWstrb;
  logic        dReady;
  logic [31:0] dRdata;
  logic        tx;
  logic        done;
  logic [7:0]  exitCode;

  int checkCount = 0;
  int failCount  = 0;
  int cycleNo    = 0;

  logic [7:0] rxBytes [$];
  int         rxStarts [$];
  int         stopErrors = 0;
  int         rxActive = 0;
  int         rxCnt = 0;
  logic [7:0] rxByte;

  riscv_console #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .d_valid  (dValid),
    .d_we     (dWe),
    .d_addr   (dAddr),
    .d_wdata  (dWdata),
    .d_wstrb  (dWstrb),
    .d_ready  (dReady),
    .d_rdata  (dRdata),
    .tx       (tx),
    .done     (done),
    .exit_code(exitCode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo++;

  // Samples mid-bit on falling edges: start seen at count 0, data bit k at 6+4k, stop at 38.
  always @(negedge clk) begin
    if (!resetn) begin
      rxActive = 0;
    end else if (rxActive == 0) begin
      if (tx == 1'b0) begin
        rxActive = 1;
        rxCnt = 0;
        rxStarts.push_back(cycleNo);
      end
    end else begin
      rxCnt++;
      if (rxCnt >= 6 && rxCnt <= 34 && (rxCnt % 4) == 2) begin
        rxByte[(rxCnt - 6) / 4] = tx;
      end
      if (rxCnt == 38) begin
        if (tx !== 1'b1) stopErrors++;
        rxBytes.push_back(rxByte);
        rxActive = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int limit,
                               output logic acked, output logic [31:0] rdata, output int ackCycle);
    @(negedge clk);
    dValid = 1'b1;
    dWe    = we;
    dAddr  = addr;
    dWdata = wdata;
    dWstrb = strb;
    acked  = 1'b0;
    rdata  = 32'h0;
    ackCycle = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (dReady) begin
        acked    = 1'b1;
        rdata    = dRdata;
        ackCycle = cycleNo;
        break;
      end
    end
    dValid = 1'b0;
    dWe    = 1'b0;
    dAddr  = 32'h0;
    dWdata = 32'h0;
    dWstrb = 4'h0;
  endtask

  task automatic busWrite(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int ackCycle);
    logic        acked;
    logic [31:0] rdata;
    applyStimulus(1'b1, addr, wdata, strb, 200, acked, rdata, ackCycle);
    checkOutput(tag, {31'h0, acked}, 32'h1);
  endtask

  task automatic busRead(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic        acked;
    logic [31:0] rdata;
    int          ackCycle;
    applyStimulus(1'b0, addr, 32'h0, 4'h0, 200, acked, rdata, ackCycle);
    checkOutput({tag, "Ack"}, {31'h0, acked}, 32'h1);
    checkOutput(tag, rdata, expected);
  endtask

  task automatic waitFrames(input int n, input int limit);
    for (int i = 0; i < limit && rxBytes.size() < n; i++) begin
      @(posedge clk);
    end
    checkOutput("frameCount", rxBytes.size(), n);
  endtask

  initial begin
    int ack;
    int ack1;
    int ack9;
    int ack10;
    int base;
    int gapErr;
    int doneCycle;
    int lowCount;
    int startsAtReset;
    logic        acked;
    logic [31:0] rdata;

    resetn = 1'b1;
    dValid = 1'b0;
    dWe    = 1'b0;
    dAddr  = 32'h0;
    dWdata = 32'h0;
    dWstrb = 4'h0;
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady", {31'h0, dReady}, 32'h0);
    checkOutput("rstRdata", dRdata, 32'h0);
    checkOutput("rstTx", {31'h0, tx}, 32'h1);
    checkOutput("rstDone", {31'h0, done}, 32'h0);
    checkOutput("rstExitCode", {24'h0, exitCode}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    busRead("exitBefore", BASE + 32'h8, 32'h0000_0000);
    busRead("statusIdle", BASE + 32'h4, 32'h0000_0002);

    // Single byte: one-cycle ack, tx falls on the following edge, LSB-first frame.
    base = rxBytes.size();
    busWrite("tx4F", BASE, 32'h0000_004F, 4'b0001, ack);
    checkOutput("txBeforeFall", {31'h0, tx}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("readyPulse", {31'h0, dReady}, 32'h0);
    checkOutput("txFall", {31'h0, tx}, 32'h0);
    waitFrames(base + 1, 100);
    checkOutput("rx4F", {24'h0, rxBytes[base]}, 32'h0000_004F);
    checkOutput("start4F", rxStarts[base], ack + 1);
    repeat (5) @(posedge clk);

    // Disabled byte lane is acked but queues nothing; an out-of-block address is never acked.
    base = rxBytes.size();
    busWrite("txNoStrb", BASE, 32'h0000_0041, 4'b0000, ack);
    busRead("statusNoStrb", BASE + 32'h4, 32'h0000_0002);
    lowCount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lowCount++;
    end
    checkOutput("txLowNoStrb", lowCount, 0);
    checkOutput("framesNoStrb", rxStarts.size(), base);
    applyStimulus(1'b1, BASE + 32'h20, 32'h55, 4'b0001, 20, acked, rdata, ack);
    checkOutput("missAck", {31'h0, acked}, 32'h0);

    // Ten back-to-back bytes: first is popped at once, eight fill the FIFO, the tenth stalls.
    base = rxBytes.size();
    busWrite("burst0", BASE, 32'h30, 4'b0001, ack1);
    for (int i = 1; i < 9; i++) begin
      busWrite("burst", BASE, 32'h30 + i, 4'b0001, ack9);
    end
    checkOutput("ack9NoStall", ack9, ack1 + 16);
    busRead("statusFull", BASE + 32'h4, 32'h0000_0805);
    busWrite("burst9", BASE, 32'h39, 4'b0001, ack10);
    waitFrames(base + 10, 600);
    for (int i = 0; i < 10; i++) begin
      checkOutput("burstByte", {24'h0, rxBytes[base + i]}, 32'h30 + i);
    end
    checkOutput("burstStart", rxStarts[base], ack1 + 1);
    checkOutput("stallRelease", ack10, rxStarts[base + 1] + 1);
    checkOutput("frameGap", rxStarts[base + 1] - rxStarts[base], 41);
    gapErr = 0;
    for (int i = 1; i < 10; i++) begin
      if (rxStarts[base + i] - rxStarts[base + i - 1] != 41) gapErr++;
    end
    checkOutput("frameGapAll", gapErr, 0);
    repeat (5) @(posedge clk);

    // "OK\n" then EXIT: done waits for the third stop bit, later EXIT writes change nothing.
    base = rxBytes.size();
    busWrite("okO", BASE, 32'h4F, 4'b0001, ack);
    busWrite("okK", BASE, 32'h4B, 4'b0001, ack);
    busWrite("okNl", BASE, 32'h0A, 4'b0001, ack);
    busWrite("exit0", BASE + 32'h8, 32'h00, 4'b0001, ack);
    busRead("statusMid", BASE + 32'h4, 32'h0000_0204);
    checkOutput("doneEarly", {31'h0, done}, 32'h0);
    doneCycle = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCycle = cycleNo;
        break;
      end
    end
    checkOutput("doneSeen", {31'h0, done}, 32'h1);
    waitFrames(base + 3, 50);
    checkOutput("okByte0", {24'h0, rxBytes[base]}, 32'h4F);
    checkOutput("okByte1", {24'h0, rxBytes[base + 1]}, 32'h4B);
    checkOutput("okByte2", {24'h0, rxBytes[base + 2]}, 32'h0A);
    checkOutput("doneTiming", doneCycle, rxStarts[base + 2] + 41);
    checkOutput("exitCode0", {24'h0, exitCode}, 32'h0);
    busWrite("exit1", BASE + 32'h8, 32'h01, 4'b0001, ack);
    checkOutput("exitCodeKept", {24'h0, exitCode}, 32'h0);
    busRead("exitRead", BASE + 32'h8, 32'h0000_0100);
    checkOutput("doneSticky", {31'h0, done}, 32'h1);

    // Reset in the middle of data bit 3 of 0xA5 (a 0 bit) with two more bytes queued.
    busWrite("rstA5", BASE, 32'hA5, 4'b0001, ack1);
    busWrite("rst11", BASE, 32'h11, 4'b0001, ack);
    busWrite("rst22", BASE, 32'h22, 4'b0001, ack);
    for (int i = 0; i < 100 && cycleNo < ack1 + 1 + 17; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("txBit3", {31'h0, tx}, 32'h0);
    #2 resetn = 1'b0;
    #1;
    checkOutput("abortTx", {31'h0, tx}, 32'h1);
    checkOutput("abortDone", {31'h0, done}, 32'h0);
    checkOutput("abortReady", {31'h0, dReady}, 32'h0);
    startsAtReset = rxStarts.size();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    lowCount = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lowCount++;
    end
    checkOutput("txLowAfterRst", lowCount, 0);
    checkOutput("framesAfterRst", rxStarts.size(), startsAtReset);
    busRead("statusAfterRst", BASE + 32'h4, 32'h0000_0002);
    busRead("exitAfterRst", BASE + 32'h8, 32'h0000_0000);
    checkOutput("stopBits", stopErrors, 0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
